// File: rtl/race_stopwatch_if.sv
// Control and display bundle between the game FSM / tick generator and the
// race stopwatch. The stopwatch is the slave: it consumes tick/start/stop/clear
// and drives the BCD display digits, binary total and status flags.
interface race_stopwatch_if;
  logic        tick;
  logic        start;
  logic        stop;
  logic        clear;
  logic [3:0]  min_t;
  logic [3:0]  min_u;
  logic [3:0]  sec_t;
  logic [3:0]  sec_u;
  logic [3:0]  cs_t;
  logic [3:0]  cs_u;
  logic [18:0] total_cs;
  logic        running;
  logic        overflow;

  modport master (
    output tick, start, stop, clear,
    input  min_t, min_u, sec_t, sec_u, cs_t, cs_u, total_cs, running, overflow
  );

  modport slave (
    input  tick, start, stop, clear,
    output min_t, min_u, sec_t, sec_u, cs_t, cs_u, total_cs, running, overflow
  );
endinterface

// File: rtl/race_stopwatch.sv
// Race stopwatch: counts accepted 100 Hz ticks as BCD mm:ss.cc plus a binary
// centisecond total, saturating at MAX_MIN:59.99.
module race_stopwatch #(
  parameter int MAX_MIN = 59
) (
  input  logic            clk,
  input  logic            rst_n,
  race_stopwatch_if.slave sw
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_u;
    logic [3:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] cs_t;
    logic [3:0] cs_u;
  } time_t;

  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);
  localparam time_t      T_MAX = '{MAX_T, MAX_U, 4'd5, 4'd9, 4'd9, 4'd9};

  state_t      state, nxt;
  time_t       tm, tm_inc;
  logic [18:0] total;
  logic        run_q, ovf_q;
  logic        acc, at_max;
  logic        w_csu, w_cst, w_secu, w_sect, w_minu;

  // A tick only counts when we are already running and not being cleared.
  assign acc    = (state == RUN) && sw.tick && !sw.clear;
  assign at_max = (tm == T_MAX);

  // Ripple-carry BCD increment of mm:ss.cc; wrap flags per digit.
  always_comb begin
    w_csu  = (tm.cs_u == 4'd9);
    w_cst  = w_csu && (tm.cs_t == 4'd9);
    w_secu = w_cst && (tm.sec_u == 4'd9);
    w_sect = w_secu && (tm.sec_t == 4'd5);
    w_minu = w_sect && (tm.min_u == 4'd9);
    tm_inc       = tm;
    tm_inc.cs_u  = w_csu ? 4'd0 : tm.cs_u + 4'd1;
    if (w_csu)  tm_inc.cs_t  = w_cst  ? 4'd0 : tm.cs_t  + 4'd1;
    if (w_cst)  tm_inc.sec_u = w_secu ? 4'd0 : tm.sec_u + 4'd1;
    if (w_secu) tm_inc.sec_t = w_sect ? 4'd0 : tm.sec_t + 4'd1;
    if (w_sect) tm_inc.min_u = w_minu ? 4'd0 : tm.min_u + 4'd1;
    if (w_minu) tm_inc.min_t = tm.min_t + 4'd1;
  end

  // Next state: clear beats stop beats start; hitting the limit ends the run.
  always_comb begin
    nxt = state;
    if (sw.clear) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: if (sw.start && !sw.stop) nxt = RUN;
        RUN: begin
          if (acc && at_max) nxt = SAT;
          else if (sw.stop)  nxt = PAUSE;
        end
        SAT:     nxt = SAT;
        default: nxt = IDLE;
      endcase
    end
  end

  // State, status flags and time registers; flags registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run_q <= 1'b0;
      ovf_q <= 1'b0;
      tm    <= '0;
      total <= '0;
    end else begin
      state <= nxt;
      run_q <= (nxt == RUN);
      ovf_q <= (nxt == SAT);
      if (sw.clear) begin
        tm    <= '0;
        total <= '0;
      end else if (acc && !at_max) begin
        tm    <= tm_inc;
        total <= total + 19'd1;
      end
    end
  end

  assign sw.min_t    = tm.min_t;
  assign sw.min_u    = tm.min_u;
  assign sw.sec_t    = tm.sec_t;
  assign sw.sec_u    = tm.sec_u;
  assign sw.cs_t     = tm.cs_t;
  assign sw.cs_u     = tm.cs_u;
  assign sw.total_cs = total;
  assign sw.running  = run_q;
  assign sw.overflow = ovf_q;

endmodule
